// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Purpose : Shared state encoding, timeout default and command record for
//           the fetch/data memory bus arbiter.
// Rev     : 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;
  localparam int unsigned WAIT_CNT_W          = 5;
  localparam logic [3:0]  FETCH_BE            = 4'hF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  function automatic mem_cmd_t make_cmd(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  be);
    mem_cmd_t cmd;
    cmd.we    = we;
    cmd.addr  = addr;
    cmd.wdata = wdata;
    cmd.be    = be;
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_bus_wait_timer
// Purpose : Per-transaction wait counter; flags the last allowed busy cycle
//           that passes without a memory ready.
// Rev     : 1.0
// ============================================================================
module mem_bus_arbiter_bus_wait_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(LIMIT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_enable & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one single-port memory between instruction fetch and
//           MEM-stage data accesses; data wins, one transaction in flight.
// Rev     : 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_be,
  output logic [31:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_block,
  output logic        o_d_block,
  output logic        o_bus_err
);

  arb_state_e  state_q,    state_d;
  mem_cmd_t    cmd_q,      cmd_d;
  logic        mem_req_q,  mem_req_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] d_rdata_q,  d_rdata_d;
  logic        d_valid_q,  d_valid_d;
  logic        bus_err_q,  bus_err_d;

  logic w_busy;
  logic w_complete;
  logic w_arb;
  logic w_expire;
  logic w_grant_data;
  logic w_grant_fetch;

  assign w_busy     = (state_q != ST_IDLE);
  assign w_complete = w_busy & i_mem_ready;
  assign w_arb      = (state_q == ST_IDLE) | w_complete;

  mem_bus_arbiter_bus_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_grant_data | w_grant_fetch),
    .i_enable (w_busy & ~i_mem_ready),
    .o_expire (w_expire)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    mem_req_d     = mem_req_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_valid_d    = 1'b0;
    d_valid_d     = 1'b0;
    bus_err_d     = 1'b0;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;

    if (w_complete) begin
      if (state_q == ST_IF_BUSY) begin
        if_rdata_d = i_mem_rdata;
        if_valid_d = 1'b1;
      end else begin
        if (!cmd_q.we) begin
          d_rdata_d = i_mem_rdata;
        end
        d_valid_d = 1'b1;
      end
    end

    if (w_expire) begin
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
      bus_err_d = 1'b1;
    end

    // The requester being completed still holds its request until it sees its
    // valid pulse, so it is excluded here to avoid serving it twice.
    if (w_arb) begin
      w_grant_data  = i_d_req & (state_q != ST_D_BUSY);
      w_grant_fetch = i_if_req & (state_q != ST_IF_BUSY) & ~w_grant_data;
      if (w_grant_data) begin
        state_d   = ST_D_BUSY;
        mem_req_d = 1'b1;
        cmd_d     = make_cmd(i_d_we, i_d_addr, i_d_wdata, i_d_be);
      end else if (w_grant_fetch) begin
        state_d   = ST_IF_BUSY;
        mem_req_d = 1'b1;
        cmd_d     = make_cmd(1'b0, i_if_addr, 32'h0, FETCH_BE);
      end else begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      mem_req_q  <= 1'b0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_valid_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mem_req_q  <= mem_req_d;
      if_rdata_q <= if_rdata_d;
      if_valid_q <= if_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_valid_q  <= d_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_be    = cmd_q.be;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_valid  = if_valid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_d_valid   = d_valid_q;
  assign o_bus_err   = bus_err_q;
  assign o_bus_block = i_if_req & ~if_valid_q;
  assign o_d_block   = i_d_req & ~d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Purpose : Directed scenarios plus randomized traffic against a memory model.
// Rev     : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_req, i_d_req, i_d_we, i_mem_ready;
  logic [31:0] i_if_addr, i_d_addr, i_d_wdata, i_mem_rdata;
  logic [3:0]  i_d_be;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_valid, o_d_valid, o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic        o_bus_block, o_d_block, o_bus_err;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_be(i_d_be),
    .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_bus_block(o_bus_block), .o_d_block(o_d_block), .o_bus_err(o_bus_err)
  );

  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    i_if_req = 1'b0; i_if_addr = '0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0; i_d_be = '0;
    i_mem_ready = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({o_mem_req, o_if_valid, o_d_valid, o_bus_err} !== 4'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: req/ifv/dv/err=%b required 0000",
               {o_mem_req, o_if_valid, o_d_valid, o_bus_err});
    end
    tests_run++;
    if ({o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_if_rdata, o_d_rdata} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_data: addr=%h wdata=%h be=%h ifr=%h dr=%h required all 0",
               o_mem_addr, o_mem_wdata, o_mem_be, o_if_rdata, o_d_rdata);
    end
    i_d_req = 1'b1; i_d_addr = 32'h2000; i_d_be = 4'hF;
    @(negedge clk);
    tests_run++;
    if (o_mem_req !== 1'b0) begin
      fail_cnt++;
      $display("FAIL grant_in_reset: req=%b required 0", o_mem_req);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h2000) begin
      fail_cnt++;
      $display("FAIL first_grant: req=%b addr=%h required 1 00002000", o_mem_req, o_mem_addr);
    end
    i_mem_ready = 1'b1; i_mem_rdata = 32'h1111_1111;
    @(negedge clk);
    tests_run++;
    if (o_d_valid !== 1'b1 || o_d_rdata !== 32'h1111_1111) begin
      fail_cnt++;
      $display("FAIL reset_first_load: dv=%b dr=%h required 1 11111111", o_d_valid, o_d_rdata);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int valids;
    i_if_req = 1'b1; i_if_addr = 32'h100;
    @(negedge clk);
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0 || o_mem_be !== 4'hF) begin
      fail_cnt++;
      $display("FAIL fetch_cmd: req=%b addr=%h we=%b be=%h required 1 00000100 0 f",
               o_mem_req, o_mem_addr, o_mem_we, o_mem_be);
    end
    @(negedge clk);
    tests_run++;
    if (o_bus_block !== 1'b1 || o_if_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL fetch_wait: block=%b ifv=%b required 1 0", o_bus_block, o_if_valid);
    end
    i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_0013;
    @(negedge clk);
    i_mem_ready = 1'b0;
    tests_run++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h13 || o_bus_block !== 1'b0) begin
      fail_cnt++;
      $display("FAIL fetch_done: ifv=%b rdata=%h block=%b required 1 00000013 0",
               o_if_valid, o_if_rdata, o_bus_block);
    end
    i_if_req = 1'b0;
    valids = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_if_valid === 1'b1) valids++;
    end
    tests_run++;
    if (valids != 0) begin
      fail_cnt++;
      $display("FAIL fetch_single_pulse: extra pulses=%0d required 0", valids);
    end
  endtask

  task automatic test_priority();
    i_if_req = 1'b1; i_if_addr = 32'h104;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h2000; i_d_be = 4'hF;
    @(negedge clk);
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h2000 || o_mem_we !== 1'b0) begin
      fail_cnt++;
      $display("FAIL prio_data_first: req=%b addr=%h we=%b required 1 00002000 0",
               o_mem_req, o_mem_addr, o_mem_we);
    end
    i_mem_ready = 1'b1; i_mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    tests_run++;
    if (o_d_valid !== 1'b1 || o_d_rdata !== 32'hCAFE_0001) begin
      fail_cnt++;
      $display("FAIL prio_load: dv=%b dr=%h required 1 cafe0001", o_d_valid, o_d_rdata);
    end
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h104) begin
      fail_cnt++;
      $display("FAIL prio_fetch_next: req=%b addr=%h required 1 00000104", o_mem_req, o_mem_addr);
    end
    i_d_req = 1'b0;
    i_mem_rdata = 32'h0000_0297;
    @(negedge clk);
    tests_run++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h297 || o_d_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL prio_fetch_done: ifv=%b ifr=%h dv=%b required 1 00000297 0",
               o_if_valid, o_if_rdata, o_d_valid);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_store();
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h2004;
    i_d_wdata = 32'hDEAD_BEEF; i_d_be = 4'b0011;
    @(negedge clk);
    tests_run++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_d_block} !==
        {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b1}) begin
      fail_cnt++;
      $display("FAIL store_cmd: req=%b we=%b addr=%h wd=%h be=%b dblk=%b required 1 1 00002004 deadbeef 0011 1",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_d_block);
    end
    i_d_wdata = 32'h0;
    i_d_addr = 32'h3000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be} !==
          {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011}) begin
        fail_cnt++;
        $display("FAIL store_stable: wait %0d addr=%h wd=%h be=%b required 00002004 deadbeef 0011",
                 k, o_mem_addr, o_mem_wdata, o_mem_be);
      end
    end
    i_mem_ready = 1'b1; i_mem_rdata = 32'h5555_5555;
    @(negedge clk);
    tests_run++;
    if (o_d_valid !== 1'b1 || o_d_rdata !== 32'hCAFE_0001 || o_d_block !== 1'b0) begin
      fail_cnt++;
      $display("FAIL store_done: dv=%b dr=%h dblk=%b required 1 cafe0001 0",
               o_d_valid, o_d_rdata, o_d_block);
    end
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (o_d_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL store_single_pulse: dv=%b required 0", o_d_valid);
    end
  endtask

  task automatic test_timeout();
    int busy, errs, valids;
    busy = 0; valids = 0; errs = 0;
    i_if_req = 1'b1; i_if_addr = 32'h200;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_if_valid === 1'b1) valids++;
      if (o_mem_req !== 1'b1) break;
      busy++;
    end
    tests_run++;
    if (busy != int'(TO)) begin
      fail_cnt++;
      $display("FAIL timeout_len: busy cycles=%0d required %0d", busy, TO);
    end
    tests_run++;
    if (o_bus_err !== 1'b1) begin
      fail_cnt++;
      $display("FAIL timeout_err: err=%b required 1", o_bus_err);
    end
    i_if_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_bus_err === 1'b1) errs++;
      if (o_if_valid === 1'b1) valids++;
    end
    tests_run++;
    if (errs != 0 || valids != 0) begin
      fail_cnt++;
      $display("FAIL timeout_pulse: extra err=%0d valids=%0d required 0 0", errs, valids);
    end
  endtask

  task automatic test_reset_mid();
    int valids;
    valids = 0;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h2008; i_d_be = 4'hF;
    @(negedge clk);
    tests_run++;
    if (o_mem_req !== 1'b1) begin
      fail_cnt++;
      $display("FAIL rstmid_busy: req=%b required 1", o_mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_if_rdata, o_d_rdata,
         o_if_valid, o_d_valid, o_bus_err} !== '0) begin
      fail_cnt++;
      $display("FAIL rstmid_clear: req=%b addr=%h ifr=%h dr=%h err=%b required all 0",
               o_mem_req, o_mem_addr, o_if_rdata, o_d_rdata, o_bus_err);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    i_mem_ready = 1'b1; i_mem_rdata = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk);
      if (o_if_valid === 1'b1 || o_d_valid === 1'b1 || o_mem_req === 1'b1) valids++;
    end
    tests_run++;
    if (valids != 0) begin
      fail_cnt++;
      $display("FAIL rstmid_stray_ready: cycles with activity=%0d required 0", valids);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int valids;
    logic prev_v;
    valids = 0; prev_v = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h300;
    i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_0093;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests_run++;
      if (o_if_valid !== ((k % 2) == 0)) begin
        fail_cnt++;
        $display("FAIL stream_cadence: cycle %0d ifv=%b required %0d", k, o_if_valid, (k % 2) == 0);
      end
      if (o_if_valid === 1'b1) valids++;
    end
    tests_run++;
    if (valids != 10) begin
      fail_cnt++;
      $display("FAIL stream_count: valids=%0d required 10", valids);
    end
    i_if_req = 1'b0;
    repeat (2) @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          if_pend, d_pend, exp_if, exp_d, prev_req, prev_rdy;
    logic [31:0] if_a, d_a, d_wd, exp_if_data, d_rdata_model;
    logic        d_w;
    logic [3:0]  d_b;
    logic [68:0] prev_cmd;
    int          waits, if_age, d_age;
    if_pend = 0; d_pend = 0; exp_if = 0; exp_d = 0; prev_req = 0; prev_rdy = 0;
    if_a = '0; d_a = '0; d_wd = '0; d_w = 1'b0; d_b = 4'hF; exp_if_data = '0;
    d_rdata_model = '0; prev_cmd = '0; waits = 0; if_age = 0; d_age = 0;
    mem_model.delete();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (o_bus_block !== (i_if_req & ~exp_if) || o_d_block !== (i_d_req & ~exp_d)) begin
        fail_cnt++;
        $display("FAIL rnd_block: cyc %0d blk=%b dblk=%b required %b %b",
                 cyc, o_bus_block, o_d_block, i_if_req & ~exp_if, i_d_req & ~exp_d);
      end
      tests_run++;
      if (o_if_valid !== exp_if || o_d_valid !== exp_d || o_bus_err !== 1'b0) begin
        fail_cnt++;
        $display("FAIL rnd_valid: cyc %0d ifv=%b dv=%b err=%b required %b %b 0",
                 cyc, o_if_valid, o_d_valid, o_bus_err, exp_if, exp_d);
      end
      if (exp_if) begin
        tests_run++;
        if (o_if_rdata !== exp_if_data) begin
          fail_cnt++;
          $display("FAIL rnd_fetch_data: cyc %0d got %h required %h", cyc, o_if_rdata, exp_if_data);
        end
        if_pend = 0;
      end
      if (exp_d) begin
        tests_run++;
        if (o_d_rdata !== d_rdata_model) begin
          fail_cnt++;
          $display("FAIL rnd_data_rdata: cyc %0d got %h required %h", cyc, o_d_rdata, d_rdata_model);
        end
        d_pend = 0;
      end
      exp_if = 0; exp_d = 0;
      if (prev_req && !prev_rdy && o_mem_req) begin
        tests_run++;
        if ({o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be} !== prev_cmd) begin
          fail_cnt++;
          $display("FAIL rnd_cmd_stable: cyc %0d got %h required %h",
                   cyc, {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be}, prev_cmd);
        end
      end
      prev_req = o_mem_req;
      prev_cmd = {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be};
      i_mem_ready = 1'b0;
      i_mem_rdata = $urandom;
      if (o_mem_req) begin
        if (waits >= 4 || $urandom_range(0, 2) != 0) begin
          i_mem_ready = 1'b1;
          waits = 0;
          if (o_mem_addr < 32'h1000) begin
            tests_run++;
            if (!if_pend || o_mem_addr !== if_a || o_mem_we !== 1'b0 || o_mem_be !== 4'hF) begin
              fail_cnt++;
              $display("FAIL rnd_fetch_cmd: cyc %0d pend=%b addr=%h we=%b be=%h required 1 %h 0 f",
                       cyc, if_pend, o_mem_addr, o_mem_we, o_mem_be, if_a);
            end
            exp_if = 1;
            exp_if_data = read_word(o_mem_addr);
            i_mem_rdata = exp_if_data;
          end else begin
            tests_run++;
            if (!d_pend || o_mem_addr !== d_a || o_mem_we !== d_w || o_mem_be !== d_b ||
                (d_w && o_mem_wdata !== d_wd)) begin
              fail_cnt++;
              $display("FAIL rnd_data_cmd: cyc %0d pend=%b addr=%h we=%b be=%h wd=%h required 1 %h %b %h %h",
                       cyc, d_pend, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata, d_a, d_w, d_b, d_wd);
            end
            exp_d = 1;
            if (d_w) begin
              mem_model[d_a] = merge_be(read_word(d_a), d_wd, d_b);
            end else begin
              d_rdata_model = read_word(d_a);
              i_mem_rdata = d_rdata_model;
            end
          end
        end else begin
          waits++;
        end
      end else begin
        i_mem_ready = ($urandom_range(0, 3) == 0);
      end
      prev_rdy = i_mem_ready;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_age = 0;
        if_a = 32'($urandom_range(0, 63)) << 2;
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; d_age = 0;
        d_a = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
        d_w = 1'($urandom_range(0, 1));
        d_wd = $urandom;
        d_b = d_w ? 4'($urandom_range(1, 15)) : 4'hF;
      end
      if (if_pend) if_age++;
      if (d_pend) d_age++;
      if (if_age > 60 || d_age > 60) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL rnd_starvation: cyc %0d if_age=%0d d_age=%0d required <=60", cyc, if_age, d_age);
        if_pend = 0; d_pend = 0; if_age = 0; d_age = 0;
      end
      i_if_req = if_pend; i_if_addr = if_a;
      i_d_req = d_pend; i_d_we = d_w; i_d_addr = d_a; i_d_wdata = d_wd; i_d_be = d_b;
    end
    idle_inputs();
    i_mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, maximum wait cycles per memory transaction before abort.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 i_if_req  in  1  fetch request; held high until o_if_valid.
REQ-005 i_if_addr  in  32  fetch address.
REQ-006 o_if_rdata  out  32  fetched instruction word.
REQ-007 o_if_valid  out  1  one-cycle fetch completion pulse.
REQ-008 i_d_req  in  1  MEM-stage load/store request; held high until o_d_valid.
REQ-009 i_d_we  in  1  1 = store, 0 = load.
REQ-010 i_d_addr  in  32  data address.
REQ-011 i_d_wdata  in  32  store data.
REQ-012 i_d_be  in  4  byte enables.
REQ-013 o_d_rdata  out  32  load data.
REQ-014 o_d_valid  out  1  one-cycle data completion pulse.
REQ-015 o_mem_req, o_mem_we (1), o_mem_addr, o_mem_wdata (32), o_mem_be (4)  out  shared single-port memory command.
REQ-016 i_mem_ready  in  1  memory accepts/completes the current command this cycle.
REQ-017 i_mem_rdata  in  32  read data, valid when i_mem_ready=1.
REQ-018 o_bus_block  out  1  fetch stall to IF/ID register.
REQ-019 o_d_block  out  1  whole-pipeline stall for a pending data access.
REQ-020 o_bus_err  out  1  one-cycle timeout pulse.

Function
REQ-021 FSM states IDLE, IF_BUSY, D_BUSY; only one transaction outstanding.
REQ-022 Arbitration in IDLE, or in a busy state on the i_mem_ready cycle: i_d_req wins over i_if_req; with neither, go to IDLE.
REQ-023 On grant, register address, we, wdata, be (fetch: we=0, be=4'hF) and hold o_mem_* stable, o_mem_req=1, until i_mem_ready or timeout.
REQ-024 Completion: on i_mem_ready in a busy state, capture i_mem_rdata into the matching o_*_rdata and pulse matching o_*_valid in the next cycle; store completions pulse o_d_valid with o_d_rdata unchanged.
REQ-025 Back-to-back: a new grant takes effect in the cycle after completion; zero idle cycles between transactions.
REQ-026 o_bus_block = i_if_req & ~o_if_valid; o_d_block = i_d_req & ~o_d_valid (combinational from registered valids).
REQ-027 Requests are not re-sampled mid-transaction; a requester dropping its request mid-transaction does not abort it; the valid still pulses.
REQ-028 Wait counter, 5 bits, clears on grant, increments per busy cycle without i_mem_ready; at TIMEOUT_CYC-1 without ready: drop o_mem_req, pulse o_bus_err next cycle, no valid pulse, return to arbitration.
REQ-029 i_mem_ready outside busy states is ignored.
REQ-030 Simultaneous timeout and i_mem_ready: ready wins, no error.

Reset
REQ-031 rst low at any time, including mid-transaction: state IDLE, counter 0, o_mem_req=0, all o_mem_* 0, o_*_rdata 0, o_*_valid 0, o_bus_err 0; no pending transaction survives.
REQ-032 First grant occurs no earlier than the first posedge after rst deasserts.

Structure
REQ-033 FSM state encodings and TIMEOUT_CYC default reside in shared def.v alongside the opcode defines.
REQ-034 Wait counter is a natural sub-module, bus_wait_timer (clear, enable, expire output).

Verification
REQ-035 Fetch only, addr 0x100, ready after 2 waits, rdata 0x00000013 -> o_if_valid pulses once with 0x00000013; o_bus_block high until that cycle.
REQ-036 i_if_req and i_d_req (load 0x2000) in the same cycle -> data granted first, fetch granted in the cycle after data completion.
REQ-037 Store 0x2004, wdata 0xDEADBEEF, be 4'b0011 -> o_mem_we=1, fields stable until ready, o_d_valid pulses, o_d_rdata unchanged.
REQ-038 i_mem_ready held low, TIMEOUT_CYC=16 -> o_mem_req drops after 16 busy cycles, o_bus_err one pulse, no valid.
REQ-039 rst asserted during D_BUSY -> all outputs 0 immediately; later stray i_mem_ready produces no valid.
REQ-040 Continuous fetch requests with ready every cycle -> one o_if_valid per 2 cycles (grant cycle + ready cycle), no idle gap.
